// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator entry front-end.
package calc_pkg;

   // Controller states: entry of A, operator, B, then compute/convert/show.
   typedef enum logic [2:0] {
      S_A    = 3'd0,
      S_OP   = 3'd1,
      S_B    = 3'd2,
      S_CALC = 3'd3,
      S_CONV = 3'd4,
      S_SHOW = 3'd5
   } state_t;

   // Arithmetic operator selected by the user.
   typedef enum logic [1:0] {
      OP_ADD = 2'd0,
      OP_SUB = 2'd1,
      OP_MUL = 2'd2
   } op_t;

   // Digit codes understood by the downstream 7-segment decoders.
   localparam logic [3:0] C_BLANK_CODE  = 4'hF;
   localparam logic [3:0] C_ERR_CODE    = 4'hE;
   localparam logic [3:0] C_OP_ADD_CODE = 4'hA;
   localparam logic [3:0] C_OP_SUB_CODE = 4'hB;
   localparam logic [3:0] C_OP_MUL_CODE = 4'hC;

   // Largest value a single operand digit can take.
   localparam logic [3:0] C_DIGIT_MAX = 4'd9;

   // Result width (max 9*9 = 81) and the conversion radix.
   localparam int unsigned RES_W = 7;
   localparam logic [6:0]  C_TEN = 7'd10;

   // Increment a decimal digit, wrapping 9 -> 0.
   function automatic logic [3:0] digit_inc(input logic [3:0] d);
      logic [3:0] r;
      if (d >= C_DIGIT_MAX) begin
         r = 4'd0;
      end else begin
         r = d + 4'd1;
      end
      return r;
   endfunction

   // Decrement a decimal digit, wrapping 0 -> 9.
   function automatic logic [3:0] digit_dec(input logic [3:0] d);
      logic [3:0] r;
      if (d == 4'd0) begin
         r = C_DIGIT_MAX;
      end else begin
         r = d - 4'd1;
      end
      return r;
   endfunction

   // Step the operator forward: ADD -> SUB -> MUL -> ADD.
   function automatic op_t op_inc(input op_t o);
      op_t r;
      case (o)
         OP_ADD:  r = OP_SUB;
         OP_SUB:  r = OP_MUL;
         default: r = OP_ADD;
      endcase
      return r;
   endfunction

   // Step the operator backward: ADD -> MUL -> SUB -> ADD.
   function automatic op_t op_dec(input op_t o);
      op_t r;
      case (o)
         OP_ADD:  r = OP_MUL;
         OP_MUL:  r = OP_SUB;
         default: r = OP_ADD;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/bcd_split.sv
// Iterative binary-to-two-digit split: subtracts ten per cycle while
// counting tens; done is raised once the remainder is below ten.
module bcd_split
   import calc_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_start,
   input  logic             i_abort,
   input  logic [RES_W-1:0] i_value,
   output logic             o_done,
   output logic [3:0]       o_tens,
   output logic [3:0]       o_ones
);

   logic             r_active;
   logic [RES_W-1:0] r_rem;
   logic [3:0]       r_tens;

   // Load on start, then peel off one ten per cycle until the remainder fits a digit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_active <= 1'b0;
         r_rem    <= 7'd0;
         r_tens   <= 4'd0;
      end else if (i_abort) begin
         r_active <= 1'b0;
         r_rem    <= 7'd0;
         r_tens   <= 4'd0;
      end else if (i_start) begin
         r_active <= 1'b1;
         r_rem    <= i_value;
         r_tens   <= 4'd0;
      end else if (r_active) begin
         if (r_rem >= C_TEN) begin
            r_rem  <= r_rem - C_TEN;
            r_tens <= r_tens + 4'd1;
         end else begin
            r_active <= 1'b0;
         end
      end else begin
         r_active <= 1'b0;
      end
   end

   assign o_done = r_active && (r_rem < C_TEN);
   assign o_tens = r_tens;
   assign o_ones = r_rem[3:0];

endmodule

// File: rtl/calc_entry_fsm.sv
// Calculator front-end: walks the user through A / operator / B entry,
// computes the result and drives two digit codes for 7-segment decoders.
module calc_entry_fsm
   import calc_pkg::*;
#(
   parameter logic [3:0] BLANK_CODE  = C_BLANK_CODE,
   parameter logic [3:0] ERR_CODE    = C_ERR_CODE,
   parameter logic [3:0] OP_ADD_CODE = C_OP_ADD_CODE,
   parameter logic [3:0] OP_SUB_CODE = C_OP_SUB_CODE,
   parameter logic [3:0] OP_MUL_CODE = C_OP_MUL_CODE
)(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_inc,
   input  logic       i_dec,
   input  logic       i_next,
   input  logic       i_clr,
   output logic [3:0] o_digit_hi,
   output logic [3:0] o_digit_lo,
   output logic       o_busy,
   output logic       o_result_valid,
   output logic       o_err
);

   state_t           r_state, w_state_nxt;
   logic [3:0]       r_a, w_a_nxt;
   logic [3:0]       r_b, w_b_nxt;
   op_t              r_op, w_op_nxt;
   logic [3:0]       r_tens, w_tens_nxt;
   logic [3:0]       r_ones, w_ones_nxt;
   logic             r_neg, w_neg_nxt;

   logic [3:0]       r_digit_hi, r_digit_lo;
   logic             r_busy, r_valid, r_err;

   logic [RES_W-1:0] w_res;
   logic             w_start;
   logic             w_conv_done;
   logic [3:0]       w_split_tens, w_split_ones;

   // Display/flag decode for a given register state; outputs are registered
   // from the next-state values so they change one edge after the pulse.
   function automatic logic [10:0] f_decode(
      input state_t     s,
      input logic [3:0] a,
      input logic [3:0] b,
      input op_t        op,
      input logic [3:0] tens,
      input logic [3:0] ones,
      input logic       neg
   );
      logic [3:0] hi, lo;
      logic       busy, valid, err;
      hi    = BLANK_CODE;
      lo    = BLANK_CODE;
      busy  = 1'b0;
      valid = 1'b0;
      err   = 1'b0;
      case (s)
         S_A: lo = a;
         S_OP: begin
            case (op)
               OP_ADD:  lo = OP_ADD_CODE;
               OP_SUB:  lo = OP_SUB_CODE;
               OP_MUL:  lo = OP_MUL_CODE;
               default: lo = BLANK_CODE;
            endcase
         end
         S_B: lo = b;
         S_CALC, S_CONV: busy = 1'b1;
         S_SHOW: begin
            valid = 1'b1;
            err   = neg;
            if (neg) begin
               hi = ERR_CODE;
               lo = BLANK_CODE;
            end else if (tens == 4'd0) begin
               hi = BLANK_CODE;
               lo = ones;
            end else begin
               hi = tens;
               lo = ones;
            end
         end
         default: begin
            hi = BLANK_CODE;
            lo = BLANK_CODE;
         end
      endcase
      return {hi, lo, busy, valid, err};
   endfunction

   // Raw arithmetic result; subtraction underflow is clamped to zero.
   always_comb begin
      w_res = 7'd0;
      case (r_op)
         OP_ADD: w_res = {3'd0, r_a} + {3'd0, r_b};
         OP_SUB: begin
            if (r_a >= r_b) begin
               w_res = {3'd0, r_a} - {3'd0, r_b};
            end else begin
               w_res = 7'd0;
            end
         end
         OP_MUL:  w_res = {3'd0, r_a} * {3'd0, r_b};
         default: w_res = 7'd0;
      endcase
   end

   assign w_start = (r_state == S_CALC) && !i_clr;

   bcd_split u_bcd_split (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_start (w_start),
      .i_abort (i_clr),
      .i_value (w_res),
      .o_done  (w_conv_done),
      .o_tens  (w_split_tens),
      .o_ones  (w_split_ones)
   );

   // Next-state logic: clr beats next beats inc beats dec; only the winner acts.
   always_comb begin
      w_state_nxt = r_state;
      w_a_nxt     = r_a;
      w_b_nxt     = r_b;
      w_op_nxt    = r_op;
      w_tens_nxt  = r_tens;
      w_ones_nxt  = r_ones;
      w_neg_nxt   = r_neg;
      if (i_clr) begin
         w_state_nxt = S_A;
         w_a_nxt     = 4'd0;
         w_b_nxt     = 4'd0;
         w_op_nxt    = OP_ADD;
         w_tens_nxt  = 4'd0;
         w_ones_nxt  = 4'd0;
         w_neg_nxt   = 1'b0;
      end else begin
         case (r_state)
            S_A: begin
               if (i_next) begin
                  w_state_nxt = S_OP;
               end else if (i_inc) begin
                  w_a_nxt = digit_inc(r_a);
               end else if (i_dec) begin
                  w_a_nxt = digit_dec(r_a);
               end else begin
                  w_a_nxt = r_a;
               end
            end
            S_OP: begin
               if (i_next) begin
                  w_state_nxt = S_B;
               end else if (i_inc) begin
                  w_op_nxt = op_inc(r_op);
               end else if (i_dec) begin
                  w_op_nxt = op_dec(r_op);
               end else begin
                  w_op_nxt = r_op;
               end
            end
            S_B: begin
               if (i_next) begin
                  w_state_nxt = S_CALC;
               end else if (i_inc) begin
                  w_b_nxt = digit_inc(r_b);
               end else if (i_dec) begin
                  w_b_nxt = digit_dec(r_b);
               end else begin
                  w_b_nxt = r_b;
               end
            end
            S_CALC: begin
               w_neg_nxt   = (r_op == OP_SUB) && (r_a < r_b);
               w_state_nxt = S_CONV;
            end
            S_CONV: begin
               if (w_conv_done) begin
                  w_tens_nxt  = w_split_tens;
                  w_ones_nxt  = w_split_ones;
                  w_state_nxt = S_SHOW;
               end else begin
                  w_state_nxt = S_CONV;
               end
            end
            S_SHOW: begin
               // Leaving the result starts a fresh calculation from a clean slate.
               if (i_next) begin
                  w_state_nxt = S_A;
                  w_a_nxt     = 4'd0;
                  w_b_nxt     = 4'd0;
                  w_op_nxt    = OP_ADD;
                  w_tens_nxt  = 4'd0;
                  w_ones_nxt  = 4'd0;
                  w_neg_nxt   = 1'b0;
               end else begin
                  w_state_nxt = S_SHOW;
               end
            end
            default: w_state_nxt = S_A;
         endcase
      end
   end

   // State registers and registered display/flag outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_A;
         r_a        <= 4'd0;
         r_b        <= 4'd0;
         r_op       <= OP_ADD;
         r_tens     <= 4'd0;
         r_ones     <= 4'd0;
         r_neg      <= 1'b0;
         r_digit_hi <= BLANK_CODE;
         r_digit_lo <= 4'd0;
         r_busy     <= 1'b0;
         r_valid    <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_a     <= w_a_nxt;
         r_b     <= w_b_nxt;
         r_op    <= w_op_nxt;
         r_tens  <= w_tens_nxt;
         r_ones  <= w_ones_nxt;
         r_neg   <= w_neg_nxt;
         {r_digit_hi, r_digit_lo, r_busy, r_valid, r_err} <=
            f_decode(w_state_nxt, w_a_nxt, w_b_nxt, w_op_nxt,
                     w_tens_nxt, w_ones_nxt, w_neg_nxt);
      end
   end

   assign o_digit_hi     = r_digit_hi;
   assign o_digit_lo     = r_digit_lo;
   assign o_busy         = r_busy;
   assign o_result_valid = r_valid;
   assign o_err          = r_err;

endmodule

// File: tb/tb_calc_entry_fsm.sv
// Self-checking bench for calc_entry_fsm: directed scenarios plus random
// button traffic compared against a behavioural calculator model.
module tb_calc_entry_fsm;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       i_inc = 1'b0;
   logic       i_dec = 1'b0;
   logic       i_next = 1'b0;
   logic       i_clr = 1'b0;
   logic [3:0] o_digit_hi, o_digit_lo;
   logic       o_busy, o_result_valid, o_err;

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural model: phase 0=A 1=OP 2=B 3=busy 4=show; op 0=add 1=sub 2=mul.
   int m_phase = 0;
   int m_a = 0;
   int m_b = 0;
   int m_op = 0;
   int m_busy_left = 0;

   always #5 clk = ~clk;

   calc_entry_fsm dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_inc          (i_inc),
      .i_dec          (i_dec),
      .i_next         (i_next),
      .i_clr          (i_clr),
      .o_digit_hi     (o_digit_hi),
      .o_digit_lo     (o_digit_lo),
      .o_busy         (o_busy),
      .o_result_valid (o_result_valid),
      .o_err          (o_err)
   );

   function automatic logic [10:0] obs();
      return {o_digit_hi, o_digit_lo, o_busy, o_result_valid, o_err};
   endfunction

   function automatic int model_res();
      if (m_op == 0) return m_a + m_b;
      else if (m_op == 1) return m_a - m_b;
      else return m_a * m_b;
   endfunction

   // Expected {hi, lo, busy, valid, err} from the model.
   function automatic logic [10:0] exp_vec();
      logic [3:0] hi, lo;
      logic busy, valid, err;
      int r;
      hi = 4'hF; lo = 4'hF; busy = 1'b0; valid = 1'b0; err = 1'b0;
      case (m_phase)
         0: lo = 4'(m_a);
         1: lo = (m_op == 0) ? 4'hA : ((m_op == 1) ? 4'hB : 4'hC);
         2: lo = 4'(m_b);
         3: busy = 1'b1;
         default: begin
            valid = 1'b1;
            r = model_res();
            if (r < 0) begin
               err = 1'b1; hi = 4'hE; lo = 4'hF;
            end else begin
               hi = ((r / 10) == 0) ? 4'hF : 4'(r / 10);
               lo = 4'(r % 10);
            end
         end
      endcase
      return {hi, lo, busy, valid, err};
   endfunction

   task automatic model_clear();
      m_phase = 0; m_a = 0; m_b = 0; m_op = 0; m_busy_left = 0;
   endtask

   task automatic model_step(input logic inc, input logic dec, input logic nxt, input logic clr);
      int r;
      if (clr) begin
         model_clear();
      end else if (m_phase <= 2) begin
         if (nxt) begin
            m_phase = m_phase + 1;
            if (m_phase == 3) begin
               r = model_res();
               if (r < 0) r = 0;
               m_busy_left = r / 10 + 2;
            end
         end else if (inc || dec) begin
            if (m_phase == 0) m_a = inc ? (m_a + 1) % 10 : (m_a + 9) % 10;
            else if (m_phase == 1) m_op = inc ? (m_op + 1) % 3 : (m_op + 2) % 3;
            else m_b = inc ? (m_b + 1) % 10 : (m_b + 9) % 10;
         end
      end else if (m_phase == 3) begin
         m_busy_left = m_busy_left - 1;
         if (m_busy_left == 0) m_phase = 4;
      end else begin
         if (nxt) model_clear();
      end
   endtask

   // One clock with the given pulses; leaves time at posedge+1.
   task automatic press(input logic inc, input logic dec, input logic nxt, input logic clr);
      i_inc = inc; i_dec = dec; i_next = nxt; i_clr = clr;
      @(posedge clk);
      #1;
      i_inc = 1'b0; i_dec = 1'b0; i_next = 1'b0; i_clr = 1'b0;
      model_step(inc, dec, nxt, clr);
   endtask

   // Enter A, operator (inc count from ADD) and B, confirming each with next.
   task automatic set_entry(input int a, input int op, input int b);
      for (int i = 0; i < a; i++) press(1'b1, 1'b0, 1'b0, 1'b0);
      press(1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < op; i++) press(1'b1, 1'b0, 1'b0, 1'b0);
      press(1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < b; i++) press(1'b1, 1'b0, 1'b0, 1'b0);
      press(1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_reset();
      logic [10:0] e;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      e = {4'hF, 4'h0, 3'b000};
      n_checks++;
      if (obs() !== e) begin
         n_fail++; $display("FAIL reset_values: got %h expected %h", obs(), e);
      end
      @(negedge clk);
      rst_n = 1'b1;
      model_clear();
      @(posedge clk);
      #1;
      n_checks++;
      if (obs() !== exp_vec()) begin
         n_fail++; $display("FAIL reset_release: got %h expected %h", obs(), exp_vec());
      end
   endtask

   task automatic test_wrap();
      logic [10:0] e;
      press(1'b0, 1'b1, 1'b0, 1'b0);
      e = {4'hF, 4'h9, 3'b000};
      n_checks++;
      if (obs() !== e) begin
         n_fail++; $display("FAIL wrap_dec: got %h expected %h", obs(), e);
      end
      press(1'b1, 1'b0, 1'b0, 1'b0);
      e = {4'hF, 4'h0, 3'b000};
      n_checks++;
      if (obs() !== e) begin
         n_fail++; $display("FAIL wrap_inc: got %h expected %h", obs(), e);
      end
   endtask

   task automatic test_add();
      logic [10:0] e;
      int n;
      set_entry(3, 0, 4);
      n = 0;
      while (o_busy && n < 30) begin n++; press(1'b0, 1'b0, 1'b0, 1'b0); end
      n_checks++;
      if (n !== 2) begin
         n_fail++; $display("FAIL add_busy_cycles: got %0d expected 2", n);
      end
      e = {4'hF, 4'h7, 3'b010};
      n_checks++;
      if (obs() !== e) begin
         n_fail++; $display("FAIL add_result: got %h expected %h", obs(), e);
      end
      press(1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_mul();
      logic [10:0] e;
      int n;
      for (int i = 0; i < 9; i++) press(1'b1, 1'b0, 1'b0, 1'b0);
      press(1'b0, 1'b0, 1'b1, 1'b0);
      press(1'b1, 1'b0, 1'b0, 1'b0);
      press(1'b1, 1'b0, 1'b0, 1'b0);
      e = {4'hF, 4'hC, 3'b000};
      n_checks++;
      if (obs() !== e) begin
         n_fail++; $display("FAIL mul_glyph: got %h expected %h", obs(), e);
      end
      press(1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 9; i++) press(1'b1, 1'b0, 1'b0, 1'b0);
      press(1'b0, 1'b0, 1'b1, 1'b0);
      n = 0;
      while (o_busy && n < 30) begin n++; press(1'b0, 1'b0, 1'b0, 1'b0); end
      n_checks++;
      if (n !== 10) begin
         n_fail++; $display("FAIL mul_busy_cycles: got %0d expected 10", n);
      end
      e = {4'h8, 4'h1, 3'b010};
      n_checks++;
      if (obs() !== e) begin
         n_fail++; $display("FAIL mul_result: got %h expected %h", obs(), e);
      end
      press(1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_sub_underflow();
      logic [10:0] e;
      int n;
      set_entry(2, 1, 7);
      n = 0;
      while (o_busy && n < 30) begin n++; press(1'b0, 1'b0, 1'b0, 1'b0); end
      e = {4'hE, 4'hF, 3'b011};
      n_checks++;
      if (obs() !== e) begin
         n_fail++; $display("FAIL sub_err_show: got %h expected %h", obs(), e);
      end
      press(1'b0, 1'b0, 1'b1, 1'b0);
      e = {4'hF, 4'h0, 3'b000};
      n_checks++;
      if (obs() !== e) begin
         n_fail++; $display("FAIL sub_next_clear: got %h expected %h", obs(), e);
      end
   endtask

   task automatic test_clr_priority();
      logic [10:0] e;
      for (int i = 0; i < 3; i++) press(1'b1, 1'b0, 1'b0, 1'b0);
      press(1'b0, 1'b0, 1'b1, 1'b0);
      press(1'b0, 1'b0, 1'b1, 1'b0);
      press(1'b1, 1'b0, 1'b0, 1'b0);
      press(1'b1, 1'b0, 1'b0, 1'b0);
      press(1'b1, 1'b0, 1'b0, 1'b1);
      e = {4'hF, 4'h0, 3'b000};
      n_checks++;
      if (obs() !== e) begin
         n_fail++; $display("FAIL clr_beats_inc: got %h expected %h", obs(), e);
      end
      press(1'b0, 1'b0, 1'b1, 1'b0);
      e = {4'hF, 4'hA, 3'b000};
      n_checks++;
      if (obs() !== e) begin
         n_fail++; $display("FAIL clr_op_reset: got %h expected %h", obs(), e);
      end
      press(1'b0, 1'b0, 1'b1, 1'b0);
      e = {4'hF, 4'h0, 3'b000};
      n_checks++;
      if (obs() !== e) begin
         n_fail++; $display("FAIL clr_b_reset: got %h expected %h", obs(), e);
      end
      press(1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_clr_conv();
      logic [10:0] e;
      set_entry(9, 2, 9);
      repeat (3) press(1'b0, 1'b0, 1'b0, 1'b0);
      e = {4'hF, 4'hF, 3'b100};
      n_checks++;
      if (obs() !== e) begin
         n_fail++; $display("FAIL conv_busy_blank: got %h expected %h", obs(), e);
      end
      press(1'b0, 1'b0, 1'b0, 1'b1);
      e = {4'hF, 4'h0, 3'b000};
      n_checks++;
      if (obs() !== e) begin
         n_fail++; $display("FAIL clr_during_conv: got %h expected %h", obs(), e);
      end
   endtask

   task automatic test_busy_drop();
      logic [10:0] e;
      int n;
      set_entry(9, 2, 9);
      n = 0;
      if (o_busy) n++;
      press(1'b1, 1'b0, 1'b0, 1'b0);
      if (o_busy) n++;
      press(1'b0, 1'b1, 1'b0, 1'b0);
      if (o_busy) n++;
      press(1'b0, 1'b0, 1'b1, 1'b0);
      if (o_busy) n++;
      press(1'b1, 1'b1, 1'b1, 1'b0);
      while (o_busy && n < 30) begin n++; press(1'b0, 1'b0, 1'b0, 1'b0); end
      n_checks++;
      if (n !== 10) begin
         n_fail++; $display("FAIL drop_busy_cycles: got %0d expected 10", n);
      end
      e = {4'h8, 4'h1, 3'b010};
      n_checks++;
      if (obs() !== e) begin
         n_fail++; $display("FAIL drop_result: got %h expected %h", obs(), e);
      end
      press(1'b1, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (obs() !== e) begin
         n_fail++; $display("FAIL show_ignores_inc: got %h expected %h", obs(), e);
      end
      press(1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_async_reset();
      logic [10:0] e;
      set_entry(5, 2, 7);
      press(1'b0, 1'b0, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      e = {4'hF, 4'h0, 3'b000};
      n_checks++;
      if (obs() !== e) begin
         n_fail++; $display("FAIL async_reset: got %h expected %h", obs(), e);
      end
      @(negedge clk);
      rst_n = 1'b1;
      model_clear();
      @(posedge clk);
      #1;
      n_checks++;
      if (obs() !== exp_vec()) begin
         n_fail++; $display("FAIL async_release: got %h expected %h", obs(), exp_vec());
      end
   endtask

   task automatic test_random();
      int r, cyc;
      logic inc, dec, nxt, clr;
      for (int it = 0; it < 8; it++) begin
         cyc = 0;
         while (m_phase != 4 && cyc < 300) begin
            r   = $urandom_range(0, 99);
            inc = (r < 35);
            dec = (r >= 25) && (r < 60);
            nxt = (r >= 85);
            clr = (r == 99);
            press(inc, dec, nxt, clr);
            cyc++;
            n_checks++;
            if (obs() !== exp_vec()) begin
               n_fail++;
               $display("FAIL random_it%0d_cyc%0d: got %h expected %h", it, cyc, obs(), exp_vec());
            end
         end
         press(1'b0, 1'b0, 1'b1, 1'b0);
         n_checks++;
         if (obs() !== exp_vec()) begin
            n_fail++; $display("FAIL random_exit_it%0d: got %h expected %h", it, obs(), exp_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_wrap();
      test_add();
      test_mul();
      test_sub_underflow();
      test_clr_priority();
      test_clr_conv();
      test_busy_drop();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
